// File: rtl/lsu_agu.sv
// Address-generation stage: computes rs1+imm, checks alignment and the DTCM window,
// and holds one entry that either issues to the LSU control unit or raises an exception.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 4
`endif

module lsu_agu #(
  parameter int               OUTS_MAX  = 1,
  parameter logic [`XLEN-1:0] DTCM_BASE = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        agu_i_valid,
  output logic                        agu_i_ready,
  input  logic                        agu_i_read,
  input  logic [`XLEN-1:0]            agu_i_rs1,
  input  logic [`XLEN-1:0]            agu_i_imm,
  input  logic [`XLEN-1:0]            agu_i_rs2,
  input  logic [1:0]                  agu_i_size,
  input  logic                        agu_i_usign,
  input  logic [`ITAG_WIDTH-1:0]      agu_i_itag,
  output logic                        agu_cmd_valid,
  input  logic                        agu_cmd_ready,
  output logic                        agu_cmd_read,
  output logic                        agu_cmd_usign,
  output logic [1:0]                  agu_cmd_size,
  output logic [`DTCM_ADDR_WIDTH-1:0] agu_cmd_addr,
  output logic [`XLEN-1:0]            agu_cmd_wdata,
  output logic [`XLEN/8-1:0]          agu_cmd_wmask,
  output logic [`ITAG_WIDTH-1:0]      agu_cmd_itag,
  input  logic                        agu_rsp_valid,
  output logic                        agu_rsp_ready,
  output logic                        agu_excp_valid,
  input  logic                        agu_excp_ready,
  output logic                        agu_excp_misalgn,
  output logic [`XLEN-1:0]            agu_excp_badaddr,
  output logic [`ITAG_WIDTH-1:0]      agu_excp_itag
);
  localparam int XW = `XLEN;
  localparam int AW = `DTCM_ADDR_WIDTH;
  localparam int TW = `ITAG_WIDTH;
  localparam int MW = XW / 8;

  typedef enum logic [1:0] {ST_EMPTY, ST_CMD, ST_EXCP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      outs_q, outs_d;
  logic            read_q, read_d;
  logic            usign_q, usign_d;
  logic [1:0]      size_q, size_d;
  logic [XW-1:0]   ea_q, ea_d;
  logic [XW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [TW-1:0]   itag_q, itag_d;
  logic            misalgn_q, misalgn_d;

  logic [XW-1:0]   ea;
  logic            misalgn, fault;
  logic [XW-1:0]   wdata_n;
  logic [MW-1:0]   wmask_n;
  logic            cmd_fire, excp_fire, drain, in_fire, rsp_dec;

  assign ea      = agu_i_rs1 + agu_i_imm;
  assign misalgn = (agu_i_size == 2'b11) ||
                   (agu_i_size == 2'b01 && ea[0]) ||
                   (agu_i_size == 2'b10 && ea[1:0] != 2'b00);
  assign fault   = ea[XW-1:AW] != DTCM_BASE[XW-1:AW];

  always_comb begin
    wdata_n = '0;
    wmask_n = '0;
    if (!agu_i_read) begin
      unique case (agu_i_size)
        2'b00: begin
          wmask_n = MW'(1) << ea[1:0];
          wdata_n = {(XW/8){agu_i_rs2[7:0]}};
        end
        2'b01: begin
          wmask_n = MW'(3) << {ea[1], 1'b0};
          wdata_n = {(XW/16){agu_i_rs2[15:0]}};
        end
        default: begin
          wmask_n = '1;
          wdata_n = agu_i_rs2;
        end
      endcase
    end
  end

  // Exceptions wait for every older DTCM access to complete.
  assign agu_cmd_valid  = (state_q == ST_CMD) && ((outs_q < 2'(OUTS_MAX)) || agu_rsp_valid);
  assign agu_excp_valid = (state_q == ST_EXCP) && (outs_q == 2'd0);
  assign cmd_fire       = agu_cmd_valid && agu_cmd_ready;
  assign excp_fire      = agu_excp_valid && agu_excp_ready;
  assign drain          = cmd_fire || excp_fire;
  assign agu_i_ready    = (state_q == ST_EMPTY) || drain;
  assign in_fire        = agu_i_valid && agu_i_ready;
  assign rsp_dec        = agu_rsp_valid && (outs_q != 2'd0);
  assign agu_rsp_ready  = 1'b1;

  always_comb begin
    state_d   = state_q;
    outs_d    = outs_q;
    read_d    = read_q;
    usign_d   = usign_q;
    size_d    = size_q;
    ea_d      = ea_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    itag_d    = itag_q;
    misalgn_d = misalgn_q;
    if (in_fire) begin
      state_d   = (misalgn || fault) ? ST_EXCP : ST_CMD;
      read_d    = agu_i_read;
      usign_d   = agu_i_usign;
      size_d    = agu_i_size;
      ea_d      = ea;
      wdata_d   = wdata_n;
      wmask_d   = wmask_n;
      itag_d    = agu_i_itag;
      misalgn_d = misalgn;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
    unique case ({cmd_fire, rsp_dec})
      2'b10:   outs_d = outs_q + 2'd1;
      2'b01:   outs_d = outs_q - 2'd1;
      default: outs_d = outs_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      outs_q    <= '0;
      read_q    <= 1'b0;
      usign_q   <= 1'b0;
      size_q    <= '0;
      ea_q      <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      itag_q    <= '0;
      misalgn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      outs_q    <= outs_d;
      read_q    <= read_d;
      usign_q   <= usign_d;
      size_q    <= size_d;
      ea_q      <= ea_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      itag_q    <= itag_d;
      misalgn_q <= misalgn_d;
    end
  end

  assign agu_cmd_read     = read_q;
  assign agu_cmd_usign    = usign_q;
  assign agu_cmd_size     = size_q;
  assign agu_cmd_addr     = ea_q[AW-1:0];
  assign agu_cmd_wdata    = wdata_q;
  assign agu_cmd_wmask    = wmask_q;
  assign agu_cmd_itag     = itag_q;
  assign agu_excp_misalgn = misalgn_q;
  assign agu_excp_badaddr = ea_q;
  assign agu_excp_itag    = itag_q;

endmodule

// File: tb/tb_lsu_agu.sv
// Scoreboard bench for lsu_agu: directed scenarios followed by randomized traffic
// checked cycle by cycle against a behavioural model of the stage and outstanding count.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 4
`endif

module tb_lsu_agu;
  localparam int XW = `XLEN;
  localparam int AW = `DTCM_ADDR_WIDTH;
  localparam int TW = `ITAG_WIDTH;
  localparam int OM = 1;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic agu_i_valid, agu_i_ready, agu_i_read, agu_i_usign;
  logic [XW-1:0] agu_i_rs1, agu_i_imm, agu_i_rs2;
  logic [1:0] agu_i_size;
  logic [TW-1:0] agu_i_itag;
  logic agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [1:0] agu_cmd_size;
  logic [AW-1:0] agu_cmd_addr;
  logic [XW-1:0] agu_cmd_wdata;
  logic [XW/8-1:0] agu_cmd_wmask;
  logic [TW-1:0] agu_cmd_itag;
  logic agu_rsp_valid, agu_rsp_ready;
  logic agu_excp_valid, agu_excp_ready, agu_excp_misalgn;
  logic [XW-1:0] agu_excp_badaddr;
  logic [TW-1:0] agu_excp_itag;

  lsu_agu #(.OUTS_MAX(OM), .DTCM_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .agu_i_valid(agu_i_valid), .agu_i_ready(agu_i_ready), .agu_i_read(agu_i_read),
    .agu_i_rs1(agu_i_rs1), .agu_i_imm(agu_i_imm), .agu_i_rs2(agu_i_rs2),
    .agu_i_size(agu_i_size), .agu_i_usign(agu_i_usign), .agu_i_itag(agu_i_itag),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_read(agu_cmd_read), .agu_cmd_usign(agu_cmd_usign), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_itag(agu_cmd_itag), .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
    .agu_excp_valid(agu_excp_valid), .agu_excp_ready(agu_excp_ready),
    .agu_excp_misalgn(agu_excp_misalgn), .agu_excp_badaddr(agu_excp_badaddr),
    .agu_excp_itag(agu_excp_itag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          excp;
    logic          misalgn;
    logic          read;
    logic          usign;
    logic [1:0]    size;
    logic [31:0]   ea;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
    logic [TW-1:0] itag;
  } exp_t;

  exp_t sb[$];
  int   m_outs = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   auto_rsp = 1'b0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written from the address/alignment/window rules.
  function automatic exp_t model(input logic rd, input logic [1:0] sz, input logic [31:0] rs1,
                                 input logic [31:0] imm, input logic [31:0] rs2,
                                 input logic us, input logic [TW-1:0] tg);
    exp_t e;
    int   off;
    e = '0;
    e.ea = rs1 + imm;
    off = int'(e.ea % 4);
    e.misalgn = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    e.excp = e.misalgn || ((e.ea >> AW) != (BASE >> AW));
    e.read = rd;
    e.usign = us;
    e.size = sz;
    e.itag = tg;
    if (!rd) begin
      if (sz == 2'd0) begin
        e.wmask = 4'(1 << off);
        e.wdata = {24'd0, rs2[7:0]} * 32'h0101_0101;
      end else if (sz == 2'd1) begin
        e.wmask = (off >= 2) ? 4'hC : 4'h3;
        e.wdata = {16'd0, rs2[15:0]} * 32'h0001_0001;
      end else begin
        e.wmask = 4'hF;
        e.wdata = rs2;
      end
    end
    return e;
  endfunction

  // Monitor: compares every cycle at the falling edge against the model stage.
  initial begin : monitor
    exp_t h;
    bit   occ, ecv, eev, drn;
    forever begin
      @(negedge clk);
      if (!rst) begin
        occ = (sb.size() != 0);
        h = occ ? sb[0] : '0;
        ecv = occ && !h.excp && (m_outs < OM || agu_rsp_valid);
        eev = occ && h.excp && (m_outs == 0);
        chk("cmd_valid", 32'(agu_cmd_valid), 32'(ecv));
        chk("excp_valid", 32'(agu_excp_valid), 32'(eev));
        chk("rsp_ready", 32'(agu_rsp_ready), 32'd1);
        if (agu_cmd_valid && ecv) begin
          chk("cmd_addr", 32'(agu_cmd_addr), 32'(h.ea[AW-1:0]));
          chk("cmd_wdata", agu_cmd_wdata, h.wdata);
          chk("cmd_wmask", 32'(agu_cmd_wmask), 32'(h.wmask));
          chk("cmd_fields", {26'd0, agu_cmd_read, agu_cmd_usign, agu_cmd_size, 2'd0},
              {26'd0, h.read, h.usign, h.size, 2'd0});
          chk("cmd_itag", 32'(agu_cmd_itag), 32'(h.itag));
        end
        if (agu_excp_valid && eev) begin
          chk("excp_misalgn", 32'(agu_excp_misalgn), 32'(h.misalgn));
          chk("excp_badaddr", agu_excp_badaddr, h.ea);
          chk("excp_itag", 32'(agu_excp_itag), 32'(h.itag));
        end
        drn = (ecv && agu_cmd_ready) || (eev && agu_excp_ready);
        chk("i_ready", 32'(agu_i_ready), 32'(!occ || drn));
        if (drn) void'(sb.pop_front());
        if (agu_i_valid && agu_i_ready)
          sb.push_back(model(agu_i_read, agu_i_size, agu_i_rs1, agu_i_imm, agu_i_rs2,
                             agu_i_usign, agu_i_itag));
        m_outs = m_outs + ((ecv && agu_cmd_ready) ? 1 : 0)
                        - ((agu_rsp_valid && m_outs > 0) ? 1 : 0);
      end
    end
  end

  // Random responder and ready generator, active only in the random phase.
  initial begin : responder
    forever begin
      @(posedge clk);
      #1;
      if (auto_rsp) agu_rsp_valid = ($urandom_range(0, 2) == 0);
      if (rand_rdy) begin
        agu_cmd_ready  = ($urandom_range(0, 3) != 0);
        agu_excp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic rd, input logic [1:0] sz, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] rs2, input logic us,
                       input logic [TW-1:0] tg, output int waits);
    agu_i_read = rd; agu_i_size = sz; agu_i_rs1 = rs1; agu_i_imm = imm;
    agu_i_rs2 = rs2; agu_i_usign = us; agu_i_itag = tg; agu_i_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (agu_i_ready || waits >= 200) break;
      waits++;
    end
    @(posedge clk);
    #1;
    agu_i_valid = 1'b0;
    if (waits >= 200) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: got no i_ready expected i_ready within 200 cycles");
    end
  endtask

  task automatic flush();
    int n;
    n = 0;
    agu_cmd_ready = 1'b1;
    agu_excp_ready = 1'b1;
    while ((sb.size() != 0 || m_outs != 0) && n < 100) begin
      agu_rsp_valid = 1'b1;
      tick(1);
      n++;
    end
    agu_rsp_valid = 1'b0;
    n_vec++;
    if (n >= 100) begin
      n_err++;
      $display("FAIL flush_timeout: got %0d pending expected 0", sb.size() + m_outs);
    end
  endtask

  initial begin : stim
    int w;
    logic [31:0] r1;
    rst = 1'b1;
    agu_i_valid = 0; agu_i_read = 0; agu_i_rs1 = 0; agu_i_imm = 0; agu_i_rs2 = 0;
    agu_i_size = 0; agu_i_usign = 0; agu_i_itag = 0;
    agu_cmd_ready = 0; agu_excp_ready = 0; agu_rsp_valid = 0;
    #12;
    chk("rst_cmd_valid", 32'(agu_cmd_valid), 32'd0);
    chk("rst_excp_valid", 32'(agu_excp_valid), 32'd0);
    chk("rst_i_ready", 32'(agu_i_ready), 32'd1);
    chk("rst_rsp_ready", 32'(agu_rsp_ready), 32'd1);
    chk("rst_payload", agu_cmd_wdata | agu_excp_badaddr | 32'(agu_cmd_wmask) | 32'(agu_cmd_addr), 32'd0);
    tick(1);
    rst = 1'b0;

    // Byte store into the window.
    issue(1'b0, 2'd0, 32'h8000_0010, 32'd3, 32'h0000_00A5, 1'b0, 4'd3, w);
    chk("st_valid", 32'(agu_cmd_valid), 32'd1);
    chk("st_addr_lo", 32'(agu_cmd_addr[11:0]), 32'h013);
    chk("st_wmask", 32'(agu_cmd_wmask), 32'h8);
    chk("st_wdata", agu_cmd_wdata, 32'hA5A5_A5A5);
    chk("st_read", 32'(agu_cmd_read), 32'd0);
    flush();

    // Half load issues; a misaligned half then waits for that load's response.
    agu_excp_ready = 1'b0;
    issue(1'b1, 2'd1, 32'h8000_0000, 32'd2, 32'h1234_5678, 1'b0, 4'd5, w);
    issue(1'b1, 2'd1, 32'h8000_0000, 32'd1, 32'h0, 1'b0, 4'd6, w);
    tick(3);
    chk("misalgn_wait", 32'(agu_excp_valid), 32'd0);
    chk("misalgn_no_cmd", 32'(agu_cmd_valid), 32'd0);
    agu_rsp_valid = 1'b1;
    tick(1);
    agu_rsp_valid = 1'b0;
    chk("misalgn_valid", 32'(agu_excp_valid), 32'd1);
    chk("misalgn_flag", 32'(agu_excp_misalgn), 32'd1);
    chk("misalgn_badaddr", agu_excp_badaddr, 32'h8000_0001);
    flush();

    // Word store outside the window, held by commit for 5 cycles.
    agu_excp_ready = 1'b0;
    issue(1'b0, 2'd2, 32'h1000_0000, 32'd0, 32'hDEAD_BEEF, 1'b0, 4'd7, w);
    for (int i = 0; i < 5; i++) begin
      chk("af_i_ready", 32'(agu_i_ready), 32'd0);
      chk("af_misalgn", 32'(agu_excp_misalgn), 32'd0);
      chk("af_badaddr", agu_excp_badaddr, 32'h1000_0000);
      tick(1);
    end
    flush();

    // Back-to-back loads: the second may only issue in the response cycle.
    agu_cmd_ready = 1'b1;
    issue(1'b1, 2'd2, 32'h8000_0100, 32'd4, 32'h0, 1'b0, 4'd1, w);
    issue(1'b1, 2'd2, 32'h8000_0200, 32'd8, 32'h0, 1'b1, 4'd2, w);
    tick(1);
    chk("b2b_blocked", 32'(agu_cmd_valid), 32'd0);
    agu_rsp_valid = 1'b1;
    #1;
    chk("b2b_rsp_cycle", 32'(agu_cmd_valid), 32'd1);
    tick(1);
    agu_rsp_valid = 1'b0;
    chk("b2b_after", 32'(agu_cmd_valid), 32'd0);
    flush();

    // Asynchronous reset in CMD with one access outstanding.
    agu_cmd_ready = 1'b1;
    issue(1'b1, 2'd2, 32'h8000_0040, 32'd0, 32'h0, 1'b0, 4'd9, w);
    issue(1'b1, 2'd0, 32'h8000_0041, 32'd0, 32'h0, 1'b0, 4'd10, w);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cmd_valid", 32'(agu_cmd_valid), 32'd0);
    chk("arst_excp_valid", 32'(agu_excp_valid), 32'd0);
    chk("arst_i_ready", 32'(agu_i_ready), 32'd1);
    chk("arst_addr", 32'(agu_cmd_addr), 32'd0);
    sb.delete();
    m_outs = 0;
    tick(1);
    rst = 1'b0;
    agu_rsp_valid = 1'b1;
    issue(1'b1, 2'd2, 32'h8000_0080, 32'd0, 32'h0, 1'b0, 4'd11, w);
    agu_rsp_valid = 1'b0;
    chk("arst_accept_waits", 32'(w), 32'd0);
    chk("arst_cmd_after", 32'(agu_cmd_valid), 32'd1);
    flush();

    // Randomized traffic, including responses that arrive with nothing outstanding.
    auto_rsp = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 2));
      r1 = ($urandom_range(0, 3) == 0) ? $urandom : {BASE[31:16], 16'($urandom)};
      issue(1'($urandom), 2'($urandom), r1, 32'($urandom_range(0, 127)) - 32'd64,
            $urandom, 1'($urandom), TW'($urandom), w);
    end
    auto_rsp = 1'b0;
    rand_rdy = 1'b0;
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
